// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALUOp classes, trap causes and the static control bundle.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t make_ctrl(input logic alu_src, input logic mem_to_reg,
                                      input logic branch, input logic jump,
                                      input logic jalr, input logic [1:0] alu_op);
    ctrl_t c;
    c.alu_src    = alu_src;
    c.mem_to_reg = mem_to_reg;
    c.branch     = branch;
    c.jump       = jump;
    c.jalr       = jalr;
    c.alu_op     = alu_op;
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: static control bundle plus classification
// flags used by the sequencing FSM.
module cu_decode
  import cu_pkg::*;
#(
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       needs_mem_o,
  output logic       writes_reg_o
);

  // Table lookup; unknown opcodes leave every control low and flag illegal.
  always_comb begin
    ctrl_o       = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
    illegal_o    = 1'b0;
    needs_mem_o  = 1'b0;
    writes_reg_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        ctrl_o       = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT);
        writes_reg_o = 1'b1;
      end
      OP_IMM: begin
        ctrl_o       = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT);
        writes_reg_o = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o       = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD);
        needs_mem_o  = 1'b1;
        writes_reg_o = 1'b1;
      end
      OP_STORE: begin
        ctrl_o      = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
        needs_mem_o = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_BR);
      end
      OP_JAL: begin
        ctrl_o       = make_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
        writes_reg_o = 1'b1;
      end
      OP_JALR: begin
        ctrl_o       = make_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD);
        writes_reg_o = 1'b1;
      end
      OP_LUI: begin
        if (EN_UPPER) begin
          ctrl_o       = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASS);
          writes_reg_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EN_UPPER) begin
          ctrl_o       = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
          writes_reg_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// illegal-opcode and memory-timeout traps and a retired-instruction counter.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 2,
  parameter bit          EN_UPPER    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RET_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               Branch,
  output logic               Jump,
  output logic               Jalr,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               PCWrite,
  output logic               busy,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [RET_W-1:0]   retired_q, retired_d;

  ctrl_t ctrl_s;
  logic  illegal_s, needs_mem_s, writes_reg_s;

  cu_decode #(.EN_UPPER(EN_UPPER)) u_decode (
    .opcode_i     (opcode_q),
    .ctrl_o       (ctrl_s),
    .illegal_o    (illegal_s),
    .needs_mem_o  (needs_mem_s),
    .writes_reg_o (writes_reg_s)
  );

  // State, latched opcode, memory wait counter, trap cause and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'b0;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Sequencing and per-state strobes; mem_ready takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    wait_d      = wait_q;
    cause_d     = cause_q;
    retired_d   = retired_q;
    instr_ready = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (illegal_s) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (needs_mem_s) begin
          wait_d  = '0;
          state_d = ST_MEM;
        end else if (writes_reg_s) begin
          state_d = ST_WB;
        end else begin
          PCWrite   = 1'b1;
          retired_d = retired_q + RET_W'(1);
          state_d   = ST_FETCH;
        end
      end
      ST_MEM: begin
        MemRead  = ctrl_s.mem_to_reg;
        MemWrite = ~ctrl_s.mem_to_reg;
        if (mem_ready) begin
          if (ctrl_s.mem_to_reg) begin
            state_d = ST_WB;
          end else begin
            PCWrite   = 1'b1;
            retired_d = retired_q + RET_W'(1);
            state_d   = ST_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        retired_d = retired_q + RET_W'(1);
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        if (trap_clr) begin
          cause_d = CAUSE_NONE;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_TRAP;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Static decode controls are visible only while an instruction is in flight.
  always_comb begin
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
        (state_q == ST_MEM) || (state_q == ST_WB)) begin
      ALUSrc   = ctrl_s.alu_src;
      MemtoReg = ctrl_s.mem_to_reg;
      Branch   = ctrl_s.branch;
      Jump     = ctrl_s.jump;
      Jalr     = ctrl_s.jalr;
      ALUOp    = ALUOP_W'(ctrl_s.alu_op);
    end else begin
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      Branch   = 1'b0;
      Jump     = 1'b0;
      Jalr     = 1'b0;
      ALUOp    = '0;
    end
  end

  assign busy       = (state_q != ST_FETCH);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: stimulus pushes the expected outputs of
// every cycle it drives; a negedge monitor pops and compares them.
module tb_multicycle_cu;
  import cu_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned TO = 4;
  localparam int unsigned RW = 6;

  typedef struct packed {
    logic          rdy;
    logic          busy;
    logic          trap;
    logic [1:0]    cause;
    logic          alu_src;
    logic          m2r;
    logic          br;
    logic          jmp;
    logic          jalr;
    logic [AW-1:0] aluop;
    logic          mrd;
    logic          mwr;
    logic          rw;
    logic          pcw;
    logic [RW-1:0] ret;
  } obs_t;

  logic clk, rst_n;
  logic a_valid, a_mr, a_tc, b_valid, b_mr, b_tc;
  logic [6:0] a_op, b_op;
  logic a_rdy, a_src, a_m2r, a_br, a_j, a_jr, a_mrd, a_mwr, a_rw, a_pcw, a_busy, a_trap;
  logic b_rdy, b_src, b_m2r, b_br, b_j, b_jr, b_mrd, b_mwr, b_rw, b_pcw, b_busy, b_trap;
  logic [AW-1:0] a_aluop, b_aluop;
  logic [1:0] a_cause, b_cause;
  logic [RW-1:0] a_ret, b_ret;
  obs_t a_obs, b_obs;

  obs_t aq[$];
  obs_t bq[$];
  logic a_en, b_en;
  logic [RW-1:0] ret_m [2];
  int n_chk, n_err;

  multicycle_cu #(.ALUOP_W(AW), .EN_UPPER(1'b1), .MEM_TIMEOUT(TO), .RET_W(RW)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(a_valid), .instr_ready(a_rdy), .opcode(a_op),
    .mem_ready(a_mr), .trap_clr(a_tc), .ALUSrc(a_src), .MemtoReg(a_m2r), .Branch(a_br),
    .Jump(a_j), .Jalr(a_jr), .ALUOp(a_aluop), .MemRead(a_mrd), .MemWrite(a_mwr),
    .RegWrite(a_rw), .PCWrite(a_pcw), .busy(a_busy), .trap(a_trap), .trap_cause(a_cause),
    .retired(a_ret)
  );

  multicycle_cu #(.ALUOP_W(AW), .EN_UPPER(1'b0), .MEM_TIMEOUT(TO), .RET_W(RW)) u_dut_noupper (
    .clk(clk), .rst_n(rst_n), .instr_valid(b_valid), .instr_ready(b_rdy), .opcode(b_op),
    .mem_ready(b_mr), .trap_clr(b_tc), .ALUSrc(b_src), .MemtoReg(b_m2r), .Branch(b_br),
    .Jump(b_j), .Jalr(b_jr), .ALUOp(b_aluop), .MemRead(b_mrd), .MemWrite(b_mwr),
    .RegWrite(b_rw), .PCWrite(b_pcw), .busy(b_busy), .trap(b_trap), .trap_cause(b_cause),
    .retired(b_ret)
  );

  assign a_obs = {a_rdy, a_busy, a_trap, a_cause, a_src, a_m2r, a_br, a_j, a_jr, a_aluop,
                  a_mrd, a_mwr, a_rw, a_pcw, a_ret};
  assign b_obs = {b_rdy, b_busy, b_trap, b_cause, b_src, b_m2r, b_br, b_j, b_jr, b_aluop,
                  b_mrd, b_mwr, b_rw, b_pcw, b_ret};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic obs_t ctl(input logic s, input logic m, input logic b, input logic j,
                               input logic jr, input logic [1:0] op);
    obs_t o = '0;
    o.alu_src = s; o.m2r = m; o.br = b; o.jmp = j; o.jalr = jr;
    o.aluop = AW'(op);
    return o;
  endfunction

  // Reference decode; kind: 0 = writes register, 1 = branch, 2 = load, 3 = store.
  task automatic ref_dec(input logic [6:0] op, input bit eu, output bit legal,
                         output int kind, output obs_t c);
    legal = 1'b1; kind = 0; c = '0;
    if (op == 7'b0110011)      c = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    else if (op == 7'b0010011) c = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    else if (op == 7'b0000011) begin c = ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00); kind = 2; end
    else if (op == 7'b0100011) begin c = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00); kind = 3; end
    else if (op == 7'b1100011) begin c = ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01); kind = 1; end
    else if (op == 7'b1101111) c = ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    else if (op == 7'b1100111) c = ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    else if (op == 7'b0110111 && eu) c = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    else if (op == 7'b0010111 && eu) c = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    else legal = 1'b0;
  endtask

  function automatic obs_t idle(input int w);
    obs_t o = '0;
    o.rdy = 1'b1;
    o.ret = ret_m[w];
    return o;
  endfunction

  task automatic step(input int w, input logic v, input logic [6:0] op, input logic mr,
                      input logic tc, input obs_t e);
    @(posedge clk);
    #1;
    if (w == 0) begin
      a_valid = v; a_op = op; a_mr = mr; a_tc = tc; aq.push_back(e); a_en = 1'b1;
    end else begin
      b_valid = v; b_op = op; b_mr = mr; b_tc = tc; bq.push_back(e); b_en = 1'b1;
    end
  endtask

  task automatic trap_seq(input int w, input logic [1:0] cause, input int c);
    obs_t e = '0;
    e.busy = 1'b1; e.trap = 1'b1; e.cause = cause; e.ret = ret_m[w];
    for (int k = 0; k < c; k++) step(w, rb(), 7'($urandom), rb(), 1'b0, e);
    step(w, rb(), 7'($urandom), rb(), 1'b1, e);
  endtask

  // One instruction: gap idle cycles, handshake, then its cycle-by-cycle outputs.
  // d = memory wait cycles before ack (>= TO never acks); stop > 0 aborts in MEM.
  task automatic issue(input int w, input logic [6:0] op, input int d, input int c,
                       input int gap, input int stop);
    bit legal, lastk, tout;
    int kind, nmem;
    obs_t on, e;
    ref_dec(op, (w == 0), legal, kind, on);
    for (int i = 0; i < gap; i++) step(w, 1'b0, 7'($urandom), rb(), rb(), idle(w));
    step(w, 1'b1, op, rb(), rb(), idle(w));
    on.busy = 1'b1;
    on.ret  = ret_m[w];
    step(w, rb(), 7'($urandom), rb(), rb(), on);
    if (!legal) begin
      trap_seq(w, 2'b01, c);
      return;
    end
    e = on;
    e.pcw = (kind == 1);
    step(w, rb(), 7'($urandom), rb(), rb(), e);
    if (kind == 1) begin
      ret_m[w] = ret_m[w] + RW'(1);
      return;
    end
    if (kind >= 2) begin
      tout = (d >= int'(TO));
      nmem = tout ? int'(TO) : d + 1;
      for (int k = 0; k < nmem; k++) begin
        if (stop != 0 && k == stop) return;
        lastk = !tout && (k == nmem - 1);
        e = on;
        e.mrd = (kind == 2);
        e.mwr = (kind == 3);
        e.pcw = lastk && (kind == 3);
        step(w, rb(), 7'($urandom), lastk, rb(), e);
      end
      if (tout) begin
        trap_seq(w, 2'b10, c);
        return;
      end
      if (kind == 3) begin
        ret_m[w] = ret_m[w] + RW'(1);
        return;
      end
    end
    e = on;
    e.rw  = 1'b1;
    e.pcw = 1'b1;
    step(w, rb(), 7'($urandom), rb(), rb(), e);
    ret_m[w] = ret_m[w] + RW'(1);
  endtask

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: reset values while rst_n is low, otherwise one queued entry per cycle.
  always @(negedge clk) begin
    obs_t rv;
    rv = '0;
    rv.rdy = 1'b1;
    if (!rst_n) begin
      chk("reset_a", a_obs, rv);
      chk("reset_b", b_obs, rv);
    end else begin
      if (a_en) begin
        if (aq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL a_queue: got empty expected entry");
        end else begin
          chk("a_cycle", a_obs, aq.pop_front());
        end
      end
      if (b_en) begin
        if (bq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL b_queue: got empty expected entry");
        end else begin
          chk("b_cycle", b_obs, bq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [9];
    logic [6:0] op;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    n_chk = 0; n_err = 0;
    a_en = 1'b0; b_en = 1'b0;
    a_valid = 1'b0; a_op = 7'b0; a_mr = 1'b0; a_tc = 1'b0;
    b_valid = 1'b0; b_op = 7'b0; b_mr = 1'b0; b_tc = 1'b0;
    ret_m[0] = '0; ret_m[1] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    issue(0, OP_R, 0, 0, 1, 0);
    issue(0, OP_LOAD, 3, 0, 0, 0);
    issue(0, OP_STORE, 0, 0, 2, 0);
    issue(0, OP_BRANCH, 0, 0, 0, 0);
    issue(0, 7'b0000000, 0, 1, 0, 0);
    issue(0, OP_LOAD, TO, 2, 0, 0);
    issue(0, OP_STORE, TO - 1, 0, 0, 0);
    issue(0, OP_LOAD, TO - 1, 0, 1, 0);
    issue(0, OP_STORE, TO + 2, 0, 0, 0);
    issue(0, OP_LUI, 0, 0, 0, 0);
    issue(0, OP_AUIPC, 0, 0, 0, 0);
    issue(0, OP_JAL, 0, 0, 0, 0);
    issue(0, OP_JALR, 0, 0, 0, 0);
    issue(0, OP_IMM, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 8)];
      issue(0, op, $urandom_range(0, TO + 1), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    // Asynchronous reset while a LOAD waits in MEM.
    issue(0, OP_LOAD, TO + 1, 0, 0, 2);
    @(posedge clk);
    #2;
    a_en = 1'b0;
    a_valid = 1'b0; a_mr = 1'b0; a_tc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    aq.delete();
    ret_m[0] = '0;
    rst_n = 1'b1;
    issue(0, OP_R, 0, 0, 0, 0);
    issue(0, OP_LOAD, 1, 0, 1, 0);

    @(posedge clk);
    #1;
    a_en = 1'b0;
    a_valid = 1'b0;
    issue(1, OP_LUI, 0, 1, 0, 0);
    issue(1, OP_AUIPC, 0, 0, 1, 0);
    issue(1, OP_R, 0, 0, 0, 0);
    issue(1, OP_STORE, 0, 0, 0, 0);
    issue(1, OP_LUI, 0, 0, 1, 0);
    step(1, 1'b0, 7'b0, 1'b0, 1'b0, idle(1));

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

- Multi-cycle RISC-V main control unit that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Generalises the single-cycle opcode decoder: opcode is accepted over a valid/ready handshake and memory waits on an acknowledge with timeout.
- Adds optional LUI/AUIPC support, illegal-opcode and memory-timeout trapping, and a retired-instruction counter.
- Sits between the instruction fetch interface and the datapath/data-memory port of the core.

## Interface
Parameters:
- ALUOP_W, 2: ALUOp width; must be ≥2, upper bits zero-filled.
- EN_UPPER, 1: 1 = LUI (0110111) and AUIPC (0010111) legal; 0 = both trap as illegal.
- MEM_TIMEOUT, 15: max cycles waiting for mem_ready in MEM before trapping; must be ≥1.
- RET_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  opcode valid.
- instr_ready  out  1  unit can accept an opcode; high only in FETCH.
- opcode  in  7  instruction opcode.
- mem_ready  in  1  data-memory acknowledge.
- trap_clr  in  1  leave TRAP.
- ALUSrc, MemtoReg, Branch, Jump, Jalr  out  1 each  static decode controls.
- ALUOp  out  ALUOP_W  ALU operation class.
- MemRead, MemWrite  out  1 each  memory strobes.
- RegWrite  out  1  register-file write pulse.
- PCWrite  out  1  PC update pulse.
- busy  out  1  high in every state except FETCH.
- trap  out  1  high in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- retired  out  RET_W  count of completed instructions.

## Operation

Decode table. Fields are ALUSrc/MemtoReg/Branch/Jump/Jalr/ALUOp:
- R 0110011: 0/0/0/0/0/10; writes register.
- I-ALU 0010011: 1/0/0/0/0/10; writes register.
- LOAD 0000011: 1/1/0/0/0/00; reads memory, writes register.
- STORE 0100011: 1/0/0/0/0/00; writes memory.
- BRANCH 1100011: 0/0/1/0/0/01.
- JAL 1101111: 0/0/0/1/0/00; writes register.
- JALR 1100111: 1/0/0/1/1/00; writes register.
- LUI: 1/0/0/0/0/11; writes register.
- AUIPC: 1/0/0/0/0/00; writes register.
- Any other opcode is illegal.

States and transitions:
- FETCH: instr_ready=1. On instr_valid, latch opcode and go to DECODE.
- DECODE: illegal opcode goes to TRAP with cause 01; otherwise go to EXEC.
- EXEC:
  - LOAD and STORE go to MEM.
  - BRANCH pulses PCWrite and goes to FETCH; counts as retired.
  - All other instructions go to WB.
- MEM:
  - MemRead (LOAD) or MemWrite (STORE) is held high every cycle in MEM.
  - On mem_ready: LOAD goes to WB; STORE pulses PCWrite and goes to FETCH, retired.
  - A wait counter clears on MEM entry and increments each cycle without mem_ready. When it reaches MEM_TIMEOUT, go to TRAP with cause 10.
- WB: RegWrite=1 and PCWrite=1 for exactly one cycle, retired increments, then go to FETCH.
- TRAP:
  - All strobes are 0; trap=1; trap_cause is held.
  - trap_clr goes to FETCH and clears trap_cause.
  - Instructions that end in TRAP do not retire.

Output rules:
- Static decode controls are driven from the latched opcode in DECODE through the final state of the instruction. They are 0 in FETCH and TRAP.
- retired wraps modulo 2^RET_W.

## Timing
- Reset (asynchronous assert): state=FETCH, every control output 0, instr_ready=1, busy=0, trap=0, trap_cause=00, retired=0, wait counter=0.
- Latency, counted from the handshake edge T (instr_valid & instr_ready sampled high):
  - R, I, JAL, JALR, LUI, AUIPC: DECODE T+1, EXEC T+2, WB T+3, next FETCH T+4.
  - BRANCH: PCWrite in EXEC at T+2; FETCH at T+3.
  - LOAD or STORE with mem_ready already high on MEM entry: MEM at T+3. LOAD has WB at T+4 and FETCH at T+5; STORE has FETCH at T+4.
  - Each memory wait cycle adds one cycle.
- mem_ready is ignored outside MEM. instr_valid is ignored outside FETCH, and opcode is not re-sampled.
- mem_ready and the timeout in the same cycle: mem_ready wins.
- trap_clr is ignored outside TRAP. trap_clr in the same cycle TRAP is entered has no effect.
- retired updates on the same edge that leaves WB, or leaves EXEC/MEM to FETCH.

## Structure
- Shared package cu_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - state enum;
  - ALUOp codes (ALU_ADD=00, ALU_BR=01, ALU_FUNCT=10, ALU_PASS=11);
  - trap-cause codes.
- Sub-module cu_decode: purely combinational opcode (plus EN_UPPER) to a static control bundle plus illegal, needs_mem and writes_reg flags.
- The top level holds the FSM, opcode register, wait counter and retired counter.

## Test plan
- Reset mid-MEM (LOAD waiting) → all outputs return to reset values immediately; retired=0; next opcode is accepted normally.
- R-type 0110011 → RegWrite and PCWrite high only at T+3; ALUOp=10 from T+1 to T+3; retired 0→1.
- LOAD with mem_ready held low for 3 cycles → MemRead high for 4 cycles, MemtoReg=1, WB one cycle later; STORE with immediate ack → MemWrite for 1 cycle, no RegWrite.
- BRANCH 1100011 → Branch=1, ALUOp=01, PCWrite at T+2, no RegWrite, back in FETCH at T+3.
- Opcode 0000000, and LUI with EN_UPPER=0 → trap=1, cause=01, retired unchanged. trap_clr → FETCH, cause=00.
- MEM_TIMEOUT=4 with mem_ready never high → TRAP, cause=10, after 4 MEM cycles. mem_ready rising on the 4th cycle instead → normal completion.
